// File: rtl/mt_reg_file_ctx_if.sv
// Register-file port bundle: decode reads, writeback write,
// and the scheduler's context-clear handshake.
interface mt_reg_file_ctx_if #(
  parameter int NUM_THREADS = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32
);
  localparam int TB = $clog2(NUM_THREADS);
  localparam int RB = $clog2(NUM_REGS);

  logic [TB-1:0]         tid_read;
  logic [RB-1:0]         a1;
  logic [RB-1:0]         a2;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic                  write_enable;
  logic [TB-1:0]         tid_write;
  logic [RB-1:0]         a3;
  logic [DATA_WIDTH-1:0] wd3;
  logic                  clr_req;
  logic [TB-1:0]         clr_tid;
  logic                  clr_ready;
  logic                  clr_busy;
  logic                  clr_done;
  logic                  init_busy;

  modport master (
    output tid_read, a1, a2,
    output write_enable, tid_write, a3, wd3,
    output clr_req, clr_tid,
    input  rd1, rd2,
    input  clr_ready, clr_busy, clr_done, init_busy
  );

  modport slave (
    input  tid_read, a1, a2,
    input  write_enable, tid_write, a3, wd3,
    input  clr_req, clr_tid,
    output rd1, rd2,
    output clr_ready, clr_busy, clr_done, init_busy
  );
endinterface

// File: rtl/mt_reg_file_ctx.sv
// Multithreaded register file with post-reset zeroing sweep
// and a per-thread context-clear engine.
module mt_reg_file_ctx #(
  parameter int NUM_THREADS = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int BYPASS      = 1
) (
  input logic               clk,
  input logic               rst,
  mt_reg_file_ctx_if.slave  bus
);
  localparam int TB = $clog2(NUM_THREADS);
  localparam int RB = $clog2(NUM_REGS);
  localparam int N  = NUM_THREADS * NUM_REGS;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    CLEAR
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [TB-1:0]         ctid;
  logic [DATA_WIDTH-1:0] mem [N];

  logic          stall;
  logic          ext_we;
  logic          sweep_we;
  logic          hide;
  logic [IW-1:0] ext_addr;
  logic [IW-1:0] sweep_addr;

  // Foreign-thread writes win the single port and stall the sweep.
  always_comb begin
    stall = (state == CLEAR)
          && bus.write_enable
          && (bus.tid_write != ctid);
    ext_we = bus.write_enable
           && (bus.a3 != '0)
           && ((state == IDLE) || stall);
    sweep_we = (state == INIT)
             || ((state == CLEAR) && !stall);
    ext_addr = {bus.tid_write, bus.a3};
    sweep_addr = (state == INIT)
               ? idx
               : {ctid, idx[RB-1:0]};
    hide = (state == INIT)
         || ((state == CLEAR)
             && (bus.tid_read == ctid));
  end

  always_ff @(posedge clk) begin
    if (ext_we)
      mem[ext_addr] <= bus.wd3;
    else if (sweep_we)
      mem[sweep_addr] <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      idx           <= '0;
      ctid          <= '0;
      bus.init_busy <= 1'b1;
      bus.clr_busy  <= 1'b0;
      bus.clr_ready <= 1'b0;
      bus.clr_done  <= 1'b0;
    end else begin
      bus.clr_done <= 1'b0;
      unique case (state)
        INIT: begin
          if (idx == IW'(N - 1)) begin
            state         <= IDLE;
            idx           <= '0;
            bus.init_busy <= 1'b0;
            bus.clr_ready <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        IDLE: begin
          if (bus.clr_req) begin
            state         <= CLEAR;
            ctid          <= bus.clr_tid;
            idx           <= '0;
            bus.clr_ready <= 1'b0;
            bus.clr_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (!stall) begin
            if (idx == IW'(NUM_REGS - 1)) begin
              state         <= IDLE;
              idx           <= '0;
              bus.clr_busy  <= 1'b0;
              bus.clr_ready <= 1'b1;
              bus.clr_done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    bus.rd1 = mem[{bus.tid_read, bus.a1}];
    if ((BYPASS != 0) && ext_we
        && (bus.tid_write == bus.tid_read)
        && (bus.a3 == bus.a1))
      bus.rd1 = bus.wd3;
    if (hide || (bus.a1 == '0))
      bus.rd1 = '0;
  end

  always_comb begin
    bus.rd2 = mem[{bus.tid_read, bus.a2}];
    if ((BYPASS != 0) && ext_we
        && (bus.tid_write == bus.tid_read)
        && (bus.a3 == bus.a2))
      bus.rd2 = bus.wd3;
    if (hide || (bus.a2 == '0))
      bus.rd2 = '0;
  end
endmodule

// File: doc/mt_reg_file_ctx.md
Name: mt_reg_file_ctx

Overview:
- Parametrised successor to the barrel-core multithreaded register file: NUM_THREADS banks of NUM_REGS registers, two asynchronous read ports and one synchronous write port.
- Adds a post-reset full-file zeroing sweep.
- Adds a per-thread context-clear engine with a req/ready handshake, used by the scheduler when a hart is (re)spawned.
- Adds optional write-to-read bypass.
- Sits between decode (reads) and writeback (write) in the barrel pipeline.

Parameters:
- NUM_THREADS, 8, number of hardware threads; power of 2, ≥2.
- DATA_WIDTH, 32, register width.
- NUM_REGS, 32, registers per thread; power of 2, ≥2; register 0 is hardwired zero.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tid_read  in  TB  thread for both reads (TB = $clog2(NUM_THREADS))
- a1, a2  in  RB  read addresses (RB = $clog2(NUM_REGS))
- rd1, rd2  out  DATA_WIDTH  read data, combinational
- write_enable  in  1  writeback strobe
- tid_write  in  TB  write thread
- a3  in  RB  write address
- wd3  in  DATA_WIDTH  write data
- clr_req  in  1  request to clear one thread context
- clr_tid  in  TB  thread to clear; sampled on accept
- clr_ready  out  1  high when a clear request can be accepted
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse on clear completion
- init_busy  out  1  post-reset sweep in progress

Behaviour:
- Storage: NUM_THREADS*NUM_REGS entries, indexed tid*NUM_REGS+addr. Storage is not reset directly; zeroing is done by the sweep.
- FSM states and outputs:
  - INIT: init_busy=1, clr_ready=0.
  - IDLE: clr_ready=1.
  - CLEAR: clr_busy=1, clr_ready=0.
- Reset values: state=INIT, sweep index=0, init_busy=1, clr_busy=0, clr_ready=0, clr_done=0.
- INIT:
  - Writes zero to entry index each cycle, index 0..NUM_THREADS*NUM_REGS-1.
  - External writes are ignored.
  - After writing the last entry, the next cycle is IDLE. INIT lasts exactly NUM_THREADS*NUM_REGS cycles after rst deasserts.
  - All reads return 0 while in INIT.
- IDLE, clear accept:
  - clr_req && clr_ready accepts the request; clr_tid is latched and the index cleared.
  - The next cycle is CLEAR.
  - clr_req while not ready is ignored and not queued.
- CLEAR:
  - Each non-stalled cycle zeroes entry ctid*NUM_REGS+index and increments index.
  - The sweep stalls (index holds) in any cycle where write_enable=1 and tid_write≠ctid; the external write has priority on the port.
  - write_enable with tid_write==ctid is discarded and does not stall the sweep.
  - Reads with tid_read==ctid return 0. Other threads read normally.
  - After the cycle that zeroes index NUM_REGS-1, the next cycle has state=IDLE and clr_done=1 for exactly one cycle; clr_ready=1 in that same cycle.
  - Unstalled clear latency is NUM_REGS cycles from the accept edge to IDLE.
- Writes: in IDLE, or in CLEAR to other threads, write_enable stores wd3 at the rising edge. Writes with a3==0 are discarded.
- Reads:
  - rd = 0 if addr==0; otherwise the stored value, subject to the INIT/CLEAR zero rules above.
  - If BYPASS=1 and an effective (non-discarded) write matches tid_write==tid_read and a3==addr≠0, rd = wd3 in the same cycle.
  - Sweep writes are never bypassed.
- Reset mid-operation: rst during CLEAR or INIT abandons the sweep with no clr_done pulse, returns to INIT, and restarts at index 0.
- Simultaneous events: clr_req in the same cycle as clr_done is accepted, since clr_ready=1 in that cycle.
- Widths: the index counter is $clog2(NUM_THREADS*NUM_REGS) bits, and comparisons use the full width; no wrap except the explicit terminal-count transition.

Test Plan:
- Reset, then run the full INIT: rst high 1 cycle with NUM_THREADS=8, NUM_REGS=32 -> init_busy high exactly 256 cycles, clr_ready rises on cycle 257, every entry reads 0.
- Write/read with bypass: write T3 r5=0xDEADBEEF while reading T3 r5 (BYPASS=1) -> rd1=0xDEADBEEF in the same cycle and afterwards. A write to r0 -> r0 still reads 0.
- Clear thread, no traffic: fill T2 r1..r31 with nonzero values, then pulse clr_req with clr_tid=2 -> clr_busy high 32 cycles, single clr_done pulse, T2 reads all 0, T1 contents unchanged.
- Clear with contention:
  - During the T2 clear, issue 5 writes to T4 -> clear takes 37 cycles and the T4 writes land.
  - A write to T2 r7=0x55 mid-clear -> dropped; r7 reads 0 after done.
- Back-to-back: clr_req held high through clr_done with clr_tid changed to 6 -> second clear accepted on the clr_done cycle; clr_ready stays low otherwise.
- Reset mid-clear: assert rst at sweep index 10 -> no clr_done, init_busy=1, full INIT of 256 cycles repeats, all entries read 0 afterwards.
